// File: rtl/rgb_scan_ctrl_pkg.sv
// rtl/rgb_scan_ctrl_pkg.sv - shared timing defaults and flag types for the RGB scan engine
//
// Purpose: default raster timing, framebuffer address width and the
//          per-cycle scan flag bundle carried down the delay pipeline.
// Ports:   none (package).
package rgb_scan_ctrl_pkg;

  localparam int RGB_H_ACTIVE = 64;
  localparam int RGB_H_FP     = 4;
  localparam int RGB_H_SYNC   = 8;
  localparam int RGB_H_BP     = 4;
  localparam int RGB_V_ACTIVE = 32;
  localparam int RGB_V_FP     = 2;
  localparam int RGB_V_SYNC   = 2;
  localparam int RGB_V_BP     = 2;
  localparam int RGB_RD_LAT   = 1;
  localparam int RGB_ADDR_W   = 11;
  localparam int RGB_DATA_W   = 16;

  // Syncs are kept in their active-low pin polarity so the pipeline tail
  // can drive the pins directly.
  typedef struct packed {
    logic act;
    logic hs_n;
    logic vs_n;
    logic fs;
  } scan_flags_t;

  localparam scan_flags_t FLAGS_IDLE = '{act: 1'b0, hs_n: 1'b1, vs_n: 1'b1, fs: 1'b0};

endpackage

// File: rtl/rgb_timing_gen.sv
// rtl/rgb_timing_gen.sv - horizontal/vertical raster counters and stage-0 scan flags
//
// Purpose: counts pixel clocks across the line and lines across the frame,
//          and decodes the stage-0 active / sync / frame-start flags.
// Ports:   clk, rst_n (sync, active-low), en (scan enable),
//          flags0 (act, hs_n, vs_n, fs for the current counter state).
module rgb_timing_gen
  import rgb_scan_ctrl_pkg::*;
#(
  parameter int H_ACTIVE = RGB_H_ACTIVE,
  parameter int H_FP     = RGB_H_FP,
  parameter int H_SYNC   = RGB_H_SYNC,
  parameter int H_BP     = RGB_H_BP,
  parameter int V_ACTIVE = RGB_V_ACTIVE,
  parameter int V_FP     = RGB_V_FP,
  parameter int V_SYNC   = RGB_V_SYNC,
  parameter int V_BP     = RGB_V_BP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output scan_flags_t flags0
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = (H_TOTAL > 2) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 2) ? $clog2(V_TOTAL) : 1;

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [31:0]   h_ext, v_ext;

  // Compare in 32 bits so sync-end boundaries equal to the total still fit.
  assign h_ext = 32'(h_cnt_q);
  assign v_ext = 32'(v_cnt_q);

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!en) begin
      // Held at the origin so re-enabling always begins a full frame.
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_ext == 32'(H_TOTAL - 1)) begin
      h_cnt_d = '0;
      v_cnt_d = (v_ext == 32'(V_TOTAL - 1)) ? '0 : v_cnt_q + VW'(1);
    end else begin
      h_cnt_d = h_cnt_q + HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    flags0.act  = en && (h_ext < 32'(H_ACTIVE)) && (v_ext < 32'(V_ACTIVE));
    flags0.hs_n = !(en && (h_ext >= 32'(H_ACTIVE + H_FP))
                       && (h_ext < 32'(H_ACTIVE + H_FP + H_SYNC)));
    flags0.vs_n = !(en && (v_ext >= 32'(V_ACTIVE + V_FP))
                       && (v_ext < 32'(V_ACTIVE + V_FP + V_SYNC)));
    flags0.fs   = en && (h_cnt_q == '0) && (v_cnt_q == '0);
  end

endmodule

// File: rtl/rgb_scan_ctrl.sv
// rtl/rgb_scan_ctrl.sv - RGB framebuffer scan engine with aligned parallel-RGB timing
//
// Purpose: walks the RGB565 framebuffer in raster order on RAM port B and
//          emits pixels aligned with hsync/vsync/de/frame_start.
// Ports:   rgb_clk, rst_n (sync, active-low), en (scan enable),
//          rgb_offset (port-B address out), rgb_data (port-B read data in),
//          pix_r/pix_g/pix_b (RGB565 fields, zero in blanking),
//          hsync/vsync (active low), de, frame_start (first visible pixel).
module rgb_scan_ctrl
  import rgb_scan_ctrl_pkg::*;
#(
  parameter int H_ACTIVE = RGB_H_ACTIVE,
  parameter int H_FP     = RGB_H_FP,
  parameter int H_SYNC   = RGB_H_SYNC,
  parameter int H_BP     = RGB_H_BP,
  parameter int V_ACTIVE = RGB_V_ACTIVE,
  parameter int V_FP     = RGB_V_FP,
  parameter int V_SYNC   = RGB_V_SYNC,
  parameter int V_BP     = RGB_V_BP,
  parameter int RD_LAT   = RGB_RD_LAT
) (
  input  logic                  rgb_clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic [RGB_ADDR_W-1:0] rgb_offset,
  input  logic [RGB_DATA_W-1:0] rgb_data,
  output logic [4:0]            pix_r,
  output logic [5:0]            pix_g,
  output logic [4:0]            pix_b,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic                  frame_start
);

  // Flags spend RD_LAT+1 cycles in the pipe plus one in the output
  // registers, matching the address register plus the RAM read latency.
  localparam int PIPE_D = RD_LAT + 1;

  if (H_ACTIVE * V_ACTIVE > (1 << RGB_ADDR_W)) begin : g_fb_too_small
    $error("rgb_scan_ctrl: visible area exceeds framebuffer size");
  end

  scan_flags_t flags0;

  rgb_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk    (rgb_clk),
    .rst_n  (rst_n),
    .en     (en),
    .flags0 (flags0)
  );

  logic [RGB_ADDR_W-1:0] addr_q, addr_d, addr_base;
  logic [RGB_ADDR_W-1:0] rgb_offset_q, rgb_offset_d;

  always_comb begin
    // Frame start reads address 0 in the same cycle the counter is cleared.
    addr_base    = flags0.fs ? '0 : addr_q;
    addr_d       = addr_base;
    rgb_offset_d = rgb_offset_q;
    if (!en) begin
      addr_d = '0;
    end else if (flags0.act) begin
      rgb_offset_d = addr_base;
      addr_d       = addr_base + RGB_ADDR_W'(1);
    end
  end

  always_ff @(posedge rgb_clk) begin
    if (!rst_n) begin
      addr_q       <= '0;
      rgb_offset_q <= '0;
    end else begin
      addr_q       <= addr_d;
      rgb_offset_q <= rgb_offset_d;
    end
  end

  scan_flags_t pipe_q [PIPE_D];
  scan_flags_t pipe_d [PIPE_D];
  scan_flags_t tail;

  always_comb begin
    pipe_d[0] = flags0;
    for (int i = 1; i < PIPE_D; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge rgb_clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_D; i++) begin
        pipe_q[i] <= FLAGS_IDLE;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  // Tail stage lines up with the cycle rgb_data holds this pixel's word.
  assign tail = pipe_q[PIPE_D-1];

  logic [4:0] pix_r_q, pix_r_d;
  logic [5:0] pix_g_q, pix_g_d;
  logic [4:0] pix_b_q, pix_b_d;
  logic       hsync_q, vsync_q, de_q, fs_q;

  always_comb begin
    pix_r_d = '0;
    pix_g_d = '0;
    pix_b_d = '0;
    if (tail.act) begin
      pix_r_d = rgb_data[15:11];
      pix_g_d = rgb_data[10:5];
      pix_b_d = rgb_data[4:0];
    end
  end

  always_ff @(posedge rgb_clk) begin
    if (!rst_n) begin
      pix_r_q <= '0;
      pix_g_q <= '0;
      pix_b_q <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      pix_r_q <= pix_r_d;
      pix_g_q <= pix_g_d;
      pix_b_q <= pix_b_d;
      hsync_q <= tail.hs_n;
      vsync_q <= tail.vs_n;
      de_q    <= tail.act;
      fs_q    <= tail.fs;
    end
  end

  assign rgb_offset  = rgb_offset_q;
  assign pix_r       = pix_r_q;
  assign pix_g       = pix_g_q;
  assign pix_b       = pix_b_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_rgb_scan_ctrl.sv
// tb/tb_rgb_scan_ctrl.sv - self-checking bench for rgb_scan_ctrl against a raster model
module tb_rgb_scan_ctrl;

  localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
  localparam int VA = 32, VFP = 2, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;

  logic        rgb_clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [10:0] rgb_offset;
  logic [15:0] rgb_data;
  logic [4:0]  pix_r;
  logic [5:0]  pix_g;
  logic [4:0]  pix_b;
  logic        hsync, vsync, de, frame_start;

  always #5 rgb_clk = ~rgb_clk;

  rgb_scan_ctrl dut (
    .rgb_clk     (rgb_clk),
    .rst_n       (rst_n),
    .en          (en),
    .rgb_offset  (rgb_offset),
    .rgb_data    (rgb_data),
    .pix_r       (pix_r),
    .pix_g       (pix_g),
    .pix_b       (pix_b),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .frame_start (frame_start)
  );

  // Port-B RAM model: registered address, one clock to data.
  logic [15:0] mem [2048];
  always @(posedge rgb_clk) rgb_data <= mem[rgb_offset];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: raster position as a plain frame-linear index, with the
  // visible address computed as line*HA+col and a three-clock output delay.
  typedef struct packed {
    bit act;
    bit hs;
    bit vs;
    bit fs;
    int addr;
  } exp_t;

  localparam exp_t IDLE = '{act: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, addr: 0};

  exp_t        hist [3];
  int          pos = 0;
  logic [10:0] exp_off = '0;
  bit          chk_on = 1'b0;

  function automatic exp_t stage0(input int p, input logic en_v);
    exp_t s;
    int line, col;
    s = IDLE;
    if (en_v) begin
      line   = p / HT;
      col    = p % HT;
      s.act  = (line < VA) && (col < HA);
      s.hs   = !((col >= HA + HFP) && (col < HA + HFP + HS));
      s.vs   = !((line >= VA + VFP) && (line < VA + VFP + VS));
      s.fs   = (p == 0);
      s.addr = line * HA + col;
    end
    return s;
  endfunction

  always @(posedge rgb_clk) begin
    exp_t s;
    s = stage0(pos, en);
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) hist[i] = IDLE;
      exp_off = '0;
      pos = 0;
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = s;
      if (s.act) exp_off = s.addr[10:0];
      pos = en ? (pos + 1) % FT : 0;
    end
  end

  logic [15:0] pix_word;
  assign pix_word = {pix_r, pix_g, pix_b};

  always @(negedge rgb_clk) begin
    if (chk_on) begin
      exp_t o;
      o = hist[2];
      chk("cyc_de", 32'(de), 32'(o.act));
      chk("cyc_hsync", 32'(hsync), 32'(o.hs));
      chk("cyc_vsync", 32'(vsync), 32'(o.vs));
      chk("cyc_frame_start", 32'(frame_start), 32'(o.fs));
      chk("cyc_pix", 32'(pix_word), o.act ? 32'(mem[o.addr]) : 32'd0);
      chk("cyc_rgb_offset", 32'(rgb_offset), 32'(exp_off));
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_de"}, 32'(de), 32'd0);
    chk({tag, "_hsync"}, 32'(hsync), 32'd1);
    chk({tag, "_vsync"}, 32'(vsync), 32'd1);
    chk({tag, "_offset"}, 32'(rgb_offset), 32'd0);
    chk({tag, "_pix"}, 32'(pix_word), 32'd0);
  endtask

  // Called at the negedge right after the input change; counts rising edges
  // until de is seen.
  task automatic wait_first_de(input string tag);
    int cnt;
    bit found;
    cnt = 0;
    found = 1'b0;
    while (cnt < 10 && !found) begin
      @(posedge rgb_clk);
      cnt++;
      @(negedge rgb_clk);
      if (de) found = 1'b1;
    end
    chk({tag, "_latency"}, 32'(cnt), 32'd3);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd1);
    chk({tag, "_first_pix"}, 32'(pix_word), 32'(mem[0]));
  endtask

  task automatic wait_pos(input int target, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge rgb_clk);
      if (pos == target) found = 1'b1;
    end
    chk({tag, "_reached"}, 32'(found), 32'd1);
  endtask

  // Runs from the current point to the next frame_start, reporting the
  // elapsed clocks, vsync-low clocks and the last visible pixel seen.
  task automatic run_to_fs(output int per, output int vs_low, output int last_pix, output bit found);
    per = 0;
    vs_low = 0;
    last_pix = -1;
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      if (!vsync) vs_low++;
      if (de) last_pix = int'(pix_word);
      @(negedge rgb_clk);
      per++;
      if (frame_start) found = 1'b1;
    end
  endtask

  initial begin
    int per, vs_low, last_pix;
    bit found;

    for (int i = 0; i < 2048; i++) mem[i] = 16'(i);
    rst_n = 1'b0;
    en    = 1'b1;

    // Reset held five clocks with en high.
    repeat (5) begin
      @(posedge rgb_clk);
      @(negedge rgb_clk);
      chk_on = 1'b1;
      chk_reset_vals("rst_hold");
    end
    rst_n = 1'b1;
    wait_first_de("rst_release");

    // First line in output time: 64 visible pixels 0..63, hsync low at 68..75.
    for (int k = 0; k < HT; k++) begin
      chk("line0_de", 32'(de), 32'(k < HA));
      if (k < HA) chk("line0_pix", 32'(pix_word), 32'(k));
      chk("line0_hsync", 32'(hsync), 32'(!(k >= 68 && k <= 75)));
      @(negedge rgb_clk);
    end

    // Frame wrap: first frame finishes at 2047, second frame measured whole.
    run_to_fs(per, vs_low, last_pix, found);
    chk("wrap1_found", 32'(found), 32'd1);
    chk("wrap1_period", 32'(per + HT), 32'(FT));
    chk("wrap1_vsync_low", 32'(vs_low), 32'd160);
    chk("wrap1_last_pix", 32'(last_pix), 32'd2047);
    chk("wrap1_first_pix", 32'(pix_word), 32'd0);
    run_to_fs(per, vs_low, last_pix, found);
    chk("wrap2_found", 32'(found), 32'd1);
    chk("wrap2_period", 32'(per), 32'd3040);
    chk("wrap2_vsync_low", 32'(vs_low), 32'd160);
    chk("wrap2_last_pix", 32'(last_pix), 32'd2047);

    // en drop at column 30 of line 3 for ten clocks.
    wait_pos(3 * HT + 30, "en_drop");
    en = 1'b0;
    repeat (2) @(negedge rgb_clk);
    chk("en_drop_still_active", 32'(de), 32'd1);
    @(negedge rgb_clk);
    chk("en_drop_idle_de", 32'(de), 32'd0);
    chk("en_drop_idle_pix", 32'(pix_word), 32'd0);
    for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
    mem[5] = 16'hF81F;
    repeat (7) @(negedge rgb_clk);
    en = 1'b1;
    wait_first_de("en_reassert");
    chk("en_reassert_offset", 32'(rgb_offset), 32'd2);
    repeat (5) @(negedge rgb_clk);
    chk("colour_de", 32'(de), 32'd1);
    chk("colour_r", 32'(pix_r), 32'd31);
    chk("colour_g", 32'(pix_g), 32'd0);
    chk("colour_b", 32'(pix_b), 32'd31);

    // One-clock reset pulse on line 20.
    wait_pos(20 * HT + 10, "mid_rst");
    rst_n = 1'b0;
    @(negedge rgb_clk);
    chk_reset_vals("mid_rst");
    rst_n = 1'b1;
    wait_first_de("mid_rst_release");

    // Random enable dropouts; every clock checked against the model.
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(3000, 50)) @(negedge rgb_clk);
      en = 1'b0;
      repeat ($urandom_range(20, 1)) @(negedge rgb_clk);
      en = 1'b1;
    end
    repeat (FT + 10) @(negedge rgb_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
